fp_add_seq: RTL
===============

Name: fp_add_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder. It is the responder side of the start/ready/sum handshake that the angle-combination and other datapath sequencers drive through their `*_add_start`, `*_add_a`, `*_add_b`, `*_add_ready` and `*_add_sum` ports.
- Two instances sit beside each combination sequencer.
- Accepts one operand pair per start pulse and returns a rounded sum after a fixed latency.

Parameters:
- EXP_LEN, 8, exponent field width
- MANTISSA_LEN, 23, stored mantissa field width (hidden bit not stored)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- start  input  1  one-cycle request pulse; a and b are valid in the same cycle
- a  input  EXP_LEN+MANTISSA_LEN+1  operand A {sign, exponent, mantissa}
- b  input  EXP_LEN+MANTISSA_LEN+1  operand B
- ready  output  1  high = idle and sum valid; combinational: ready_q & ~start
- sum  output  EXP_LEN+MANTISSA_LEN+1  registered result, held until the next accepted start

Behaviour:
- Reset (reset==0 at an edge, from any state, including mid-operation):
  - state->IDLE, ready_q=1, sum=0, all pipeline registers cleared.
  - An in-flight operation is discarded and no result is produced.
- Handshake:
  - ready is gated by start, so ready reads 0 in the start cycle itself.
  - An initiator that samples ready one edge after raising start therefore never sees a stale 1.
- Start acceptance:
  - start is accepted only in IDLE; the edge clears ready_q and captures a and b.
  - start while busy is ignored; no queuing, and the current result is unaffected.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - Each non-IDLE state is exactly one cycle.
  - sum is updated and ready_q set on the edge leaving ROUND.
  - Latency: ready=1 and sum valid in the 6th cycle after the start cycle.
  - Back-to-back: a new start is legal in the first cycle ready=1.
- UNPACK:
  - Prepend the hidden bit when exp!=0.
  - exp==0 is treated as zero; denormal inputs flush to zero.
  - exp==all-ones is treated as infinity; NaN is not distinguished.
- ALIGN:
  - Swap so that |A| >= |B|, comparing exponent then mantissa.
  - Right-shift the smaller significand by the exponent difference into a guard/round/sticky extension.
  - Shift >= MANTISSA_LEN+3 leaves only sticky.
- ADD:
  - Add significands if signs are equal, else subtract small from large.
  - Width is MANTISSA_LEN+5 bits: carry, hidden bit, mantissa, G, R, S.
- NORM:
  - On carry out: shift right 1 and increment the exponent, folding the lost bit into sticky.
  - Otherwise: left-shift by the leading-zero count (single-cycle) and subtract it from the exponent.
  - Exponent underflow (result exponent <= 0) flushes to signed zero.
- ROUND: mode per the Optional Feature; a mantissa overflow from rounding re-normalizes and increments the exponent.
- Special cases:
  - Exponent reaching all-ones gives signed infinity (mantissa 0).
  - Infinity plus finite gives that infinity.
  - +inf + -inf gives 0x7FC00000.
  - x + (-x) with exact zero gives +0.
  - (-0) + (-0) gives -0.
  - Zero operand: result is the other operand unchanged.
- Exponent increment (+1, as used for the multiply-by-2 detail bit) is done by the caller; this block performs no scaling.

Optional Feature:
- Macro: FP_ADD_ROUND_RNE_EN.
- Defined: round-to-nearest-even using G/R/S; increment if G & (R | S | lsb).
- Undefined: truncate (round toward zero); G/R/S are discarded, and the ROUND state still takes one cycle so latency is identical.

Decomposition:
- Package fp_pkg:
  - Constants EXP_LEN, MANTISSA_LEN, EXP_BIAS=127, EXP_MAX=255.
  - typedef fp_t: packed struct {sign, exp, man}.
  - typedef fp_add_state_e: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND.
  - Constant QNAN=32'h7FC00000.
- One sub-module: fp_lzc, a parameterized combinational leading-zero counter on a MANTISSA_LEN+5-bit vector, used in NORM.

Test Plan:
- Simple add: a=0x3F800000, b=0x40000000, one-cycle start -> ready=0 from the start cycle through cycle 5; ready=1 with sum=0x40400000 in cycle 6; sum holds until the next start.
- Cancellation: a=0x3FC00000, b=0xBFC00000 -> sum=0x00000000 (+0). a=0x80000000, b=0x80000000 -> sum=0x80000000.
- Rounding tie: a=0x3F800000, b=0x33C00000 -> 0x3F800001 with FP_ADD_ROUND_RNE_EN, 0x3F800000 without. a=0x3F800000, b=0x33800000 -> 0x3F800000 in both modes (tie to even).
- Overflow and specials:
  - a=b=0x7F7FFFFF -> 0x7F800000.
  - a=0x7F800000, b=0xFF800000 -> 0x7FC00000.
  - a=0x7F800000, b=0x3F800000 -> 0x7F800000.
- Protocol: start pulsed again in cycle 3 while busy with a=0x3F000000, b=0x3E800000 -> ignored, the first result is unchanged. Re-issued in the ready cycle -> 0x3F400000 six cycles later. Start with reset=0 -> no effect.
- Reset mid-op: reset=0 during the ALIGN cycle -> next cycle ready=1, sum=0, no later spurious sum. A subsequent start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, payload type and FSM encoding for the sequential single-precision adder.
package fp_pkg;
  localparam int unsigned EXP_LEN      = 8;
  localparam int unsigned MANTISSA_LEN = 23;
  localparam int unsigned EXP_BIAS     = 127;
  localparam int unsigned EXP_MAX      = 255;
  localparam logic [31:0] QNAN         = 32'h7FC0_0000;

  typedef struct packed {
    logic                    sign;
    logic [EXP_LEN-1:0]      exp;
    logic [MANTISSA_LEN-1:0] man;
  } fp_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND
  } fp_add_state_e;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports WIDTH.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = fp_pkg::MANTISSA_LEN + 5,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt_c
);
  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt_c = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) cnt_c = CNT_W'(WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder behind a start/ready handshake, result six cycles after start.
// Define FP_ADD_ROUND_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_add_seq #(
  parameter int unsigned EXP_LEN      = fp_pkg::EXP_LEN,
  parameter int unsigned MANTISSA_LEN = fp_pkg::MANTISSA_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [EXP_LEN+MANTISSA_LEN:0] a,
  input  logic [EXP_LEN+MANTISSA_LEN:0] b,
  output logic                          ready,
  output logic [EXP_LEN+MANTISSA_LEN:0] sum
);
  import fp_pkg::*;

  localparam int unsigned W     = EXP_LEN + MANTISSA_LEN + 1;
  localparam int unsigned SIG_W = MANTISSA_LEN + 1;
  localparam int unsigned EXT_W = MANTISSA_LEN + 4;
  localparam int unsigned ADD_W = MANTISSA_LEN + 5;
  localparam int unsigned EW    = EXP_LEN + 2;
  localparam int unsigned LZ_W  = $clog2(ADD_W + 1);

  localparam logic [EXP_LEN-1:0]      EXP_ONES = '1;
  localparam logic [MANTISSA_LEN-1:0] MAN_ZERO = '0;
  localparam logic [W-2:0]            MAG_ZERO = '0;
  localparam logic [W-1:0]            QNAN_W   = {1'b0, EXP_ONES, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

`ifdef FP_ADD_ROUND_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  fp_add_state_e state_q, state_d;
  logic                    ready_q, ready_d;
  logic [W-1:0]            sum_q, sum_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [EXP_LEN-1:0]      ea_q, ea_d, eb_q, eb_d;
  logic [SIG_W-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            spec_val_q, spec_val_d;
  logic                    sign_l_q, sign_l_d, sub_q, sub_d;
  logic [EXP_LEN-1:0]      exp_l_q, exp_l_d;
  logic [EXT_W-1:0]        sig_l_q, sig_l_d, sig_s_q, sig_s_d;
  logic [ADD_W-1:0]        add_q, add_d;
  logic [ADD_W-1:0]        nvec_q, nvec_d;
  logic [EW-1:0]           nexp_q, nexp_d;
  logic                    zero_q, zero_d, zsign_q, zsign_d;

  logic [EXP_LEN-1:0]      a_exp_c, b_exp_c;
  logic                    a_inf_c, b_inf_c, a_zero_c, b_zero_c;
  logic                    spec_c;
  logic [W-1:0]            spec_val_c;
  logic                    a_ge_c;
  logic [EXP_LEN-1:0]      shamt_c;
  logic [EXT_W-1:0]        s_ext_c, s_shift_c, sig_s_c;
  logic [ADD_W-1:0]        add_c;
  logic [LZ_W-1:0]         lz_c;
  logic [EW-1:0]           nexp_c;
  logic                    round_up_c;
  logic [SIG_W:0]          rnd_c;
  logic [EW-1:0]           rexp_c;
  logic [MANTISSA_LEN-1:0] man_c;
  logic [W-1:0]            result_c;

  assign ready = ready_q & ~start;
  assign sum   = sum_q;

  // Operand classification: exp==0 is zero (denormals flush), all-ones is infinity.
  assign a_exp_c  = a_q[W-2:MANTISSA_LEN];
  assign b_exp_c  = b_q[W-2:MANTISSA_LEN];
  assign a_inf_c  = (a_exp_c == EXP_ONES);
  assign b_inf_c  = (b_exp_c == EXP_ONES);
  assign a_zero_c = (a_exp_c == '0);
  assign b_zero_c = (b_exp_c == '0);

  always_comb begin : unpack_special
    spec_c     = 1'b1;
    spec_val_c = '0;
    if (a_inf_c && b_inf_c)
      spec_val_c = (a_q[W-1] == b_q[W-1]) ? {a_q[W-1], EXP_ONES, MAN_ZERO} : QNAN_W;
    else if (a_inf_c)             spec_val_c = {a_q[W-1], EXP_ONES, MAN_ZERO};
    else if (b_inf_c)             spec_val_c = {b_q[W-1], EXP_ONES, MAN_ZERO};
    else if (a_zero_c && b_zero_c) spec_val_c = {a_q[W-1] & b_q[W-1], MAG_ZERO};
    else if (a_zero_c)            spec_val_c = b_q;
    else if (b_zero_c)            spec_val_c = a_q;
    else                          spec_c     = 1'b0;
  end

  // Order by magnitude, then shift the smaller significand into G/R/S with sticky collection.
  always_comb begin : align_shift
    a_ge_c    = ({ea_q, ma_q} >= {eb_q, mb_q});
    shamt_c   = a_ge_c ? (ea_q - eb_q) : (eb_q - ea_q);
    s_ext_c   = {(a_ge_c ? mb_q : ma_q), 3'b000};
    s_shift_c = s_ext_c >> shamt_c;
    if (shamt_c >= EXP_LEN'(EXT_W - 1))
      sig_s_c = EXT_W'(s_ext_c != '0);
    else
      sig_s_c = s_shift_c | EXT_W'((s_shift_c << shamt_c) != s_ext_c);
  end

  assign add_c = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                       : ({1'b0, sig_l_q} + {1'b0, sig_s_q});

  fp_lzc #(.WIDTH(ADD_W), .CNT_W(LZ_W)) u_lzc (
    .vec   (add_q),
    .cnt_c (lz_c)
  );

  // Leading one moves to the carry position; carry-out keeps its place, so exp = exp_l + 1 - lz.
  assign nexp_c = EW'(exp_l_q) + EW'(1) - EW'(lz_c);

  always_comb begin : round_pack
    round_up_c = RNE_EN & nvec_q[3] & (nvec_q[2] | (|nvec_q[1:0]) | nvec_q[4]);
    rnd_c      = {1'b0, nvec_q[ADD_W-1:4]} + (SIG_W+1)'(round_up_c);
    rexp_c     = nexp_q + EW'(rnd_c[SIG_W]);
    man_c      = rnd_c[SIG_W] ? rnd_c[MANTISSA_LEN:1] : rnd_c[MANTISSA_LEN-1:0];
    if (spec_q)                         result_c = spec_val_q;
    else if (zero_q)                    result_c = {zsign_q, MAG_ZERO};
    else if (rexp_c >= EW'(EXP_ONES))   result_c = {sign_l_q, EXP_ONES, MAN_ZERO};
    else                                result_c = {sign_l_q, rexp_c[EXP_LEN-1:0], man_c};
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    ready_d    = ready_q;
    sum_d      = sum_q;
    a_d        = a_q;
    b_d        = b_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    sign_l_d   = sign_l_q;
    sub_d      = sub_q;
    exp_l_d    = exp_l_q;
    sig_l_d    = sig_l_q;
    sig_s_d    = sig_s_q;
    add_d      = add_q;
    nvec_d     = nvec_q;
    nexp_d     = nexp_q;
    zero_d     = zero_q;
    zsign_d    = zsign_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = UNPACK;
          ready_d = 1'b0;
          a_d     = a;
          b_d     = b;
        end
      end
      UNPACK: begin
        state_d    = ALIGN;
        sa_d       = a_q[W-1];
        sb_d       = b_q[W-1];
        ea_d       = a_exp_c;
        eb_d       = b_exp_c;
        ma_d       = {~a_zero_c, a_q[MANTISSA_LEN-1:0]};
        mb_d       = {~b_zero_c, b_q[MANTISSA_LEN-1:0]};
        spec_d     = spec_c;
        spec_val_d = spec_val_c;
      end
      ALIGN: begin
        state_d  = ADD;
        sign_l_d = a_ge_c ? sa_q : sb_q;
        sub_d    = sa_q ^ sb_q;
        exp_l_d  = a_ge_c ? ea_q : eb_q;
        sig_l_d  = {(a_ge_c ? ma_q : mb_q), 3'b000};
        sig_s_d  = sig_s_c;
      end
      ADD: begin
        state_d = NORM;
        add_d   = add_c;
      end
      NORM: begin
        state_d = ROUND;
        nvec_d  = add_q << lz_c;
        nexp_d  = nexp_c;
        zero_d  = (add_q == '0) || nexp_c[EW-1] || (nexp_c == '0);
        zsign_d = (add_q == '0) ? 1'b0 : sign_l_q;
      end
      ROUND: begin
        state_d = IDLE;
        ready_d = 1'b1;
        sum_d   = result_c;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      sum_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sign_l_q   <= 1'b0;
      sub_q      <= 1'b0;
      exp_l_q    <= '0;
      sig_l_q    <= '0;
      sig_s_q    <= '0;
      add_q      <= '0;
      nvec_q     <= '0;
      nexp_q     <= '0;
      zero_q     <= 1'b0;
      zsign_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      sum_q      <= sum_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      sign_l_q   <= sign_l_d;
      sub_q      <= sub_d;
      exp_l_q    <= exp_l_d;
      sig_l_q    <= sig_l_d;
      sig_s_q    <= sig_s_d;
      add_q      <= add_d;
      nvec_q     <= nvec_d;
      nexp_q     <= nexp_d;
      zero_q     <= zero_d;
      zsign_q    <= zsign_d;
    end
  end
endmodule
